// File: rtl/fir_decimator_if.sv
// ---------------------------------------------------------------------------
// fir_decimator_if -- AXI-Stream style beat bundle (tdata/tvalid/tlast/tready)
// used around the decimator.
//   master : drives tdata, tvalid, tlast; receives tready
//   slave  : receives tdata, tvalid, tlast; drives tready
// ---------------------------------------------------------------------------
interface fir_decimator_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/fir_decimator.sv
// ---------------------------------------------------------------------------
// fir_decimator -- keep-one-in-N sample decimator with frame alignment.
//
// Keeps the input beat at phase 0 of each N-beat group, plus every tlast beat,
// and restarts the phase after tlast so each frame begins with a kept sample.
// Kept beats go through a 2-entry FIFO whose head drives the output stream.
//
// Ports
//   clk                input   rising-edge clock
//   reset              input   synchronous, active-high reset
//   s_axis_dec_tdata   input   DATA_WIDTH  input sample
//   s_axis_dec_tvalid  input   input beat valid
//   s_axis_dec_tlast   input   last sample of input frame
//   s_axis_dec_tready  output  block can accept a beat
//   m_axis_dec_tdata   output  DATA_WIDTH  decimated sample (FIFO head)
//   m_axis_dec_tvalid  output  FIFO not empty
//   m_axis_dec_tlast   output  last decimated sample of frame
//   m_axis_dec_tready  input   downstream can accept a beat
//   frame_count        output  16  frames completed at the output, wrapping
// ---------------------------------------------------------------------------
module fir_decimator #(
  parameter int DATA_WIDTH   = 16,
  parameter int DECIM_FACTOR = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_axis_dec_tdata,
  input  logic                  s_axis_dec_tvalid,
  input  logic                  s_axis_dec_tlast,
  output logic                  s_axis_dec_tready,
  output logic [DATA_WIDTH-1:0] m_axis_dec_tdata,
  output logic                  m_axis_dec_tvalid,
  output logic                  m_axis_dec_tlast,
  input  logic                  m_axis_dec_tready,
  output logic [15:0]           frame_count
);

  localparam int PHASE_W = (DECIM_FACTOR > 1) ? $clog2(DECIM_FACTOR) : 1;
  localparam logic [PHASE_W-1:0] PHASE_MAX = PHASE_W'(DECIM_FACTOR - 1);

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  // FIFO: head_q is the entry on the output, tail_q the one behind it.
  beat_t               head_q, head_d;
  beat_t               tail_q, tail_d;
  logic [1:0]          count_q, count_d;
  logic [PHASE_W-1:0]  phase_q, phase_d;
  logic [15:0]         frame_q, frame_d;

  logic  s_fire, m_fire, keep, push;
  beat_t in_beat;

  // Ready depends only on registered occupancy and reset, never on the
  // downstream ready, so no combinational path crosses the block.
  assign s_axis_dec_tready = !reset && (count_q != 2'd2);
  assign m_axis_dec_tvalid = !reset && (count_q != 2'd0);
  assign m_axis_dec_tdata  = reset ? '0   : head_q.data;
  assign m_axis_dec_tlast  = reset ? 1'b0 : head_q.last;
  assign frame_count       = frame_q;

  assign s_fire  = s_axis_dec_tvalid && s_axis_dec_tready;
  assign m_fire  = m_axis_dec_tvalid && m_axis_dec_tready;
  assign keep    = (phase_q == '0) || s_axis_dec_tlast;
  assign push    = s_fire && keep;
  assign in_beat = '{last: s_axis_dec_tlast, data: s_axis_dec_tdata};

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    phase_d = phase_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    frame_d = frame_q;

    // tlast restarts the phase so the next frame opens with a kept beat.
    if (s_fire) begin
      if (s_axis_dec_tlast || (phase_q == PHASE_MAX)) phase_d = '0;
      else                                            phase_d = phase_q + 1'b1;
    end

    // Discarded beats do not touch the FIFO; a pop still proceeds.
    unique case ({push, m_fire})
      2'b10: begin
        if (count_q == 2'd0) head_d = in_beat;
        else                 tail_d = in_beat;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      // Push is only possible below 2 entries and pop needs at least 1, so
      // this is the single-entry case: the new beat replaces the head.
      2'b11: head_d = in_beat;
      default: ;
    endcase

    if (m_fire && head_q.last) frame_d = frame_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the FIFO storage is reset too (it is only two words), so the
      // output data reads zero after reset instead of stale contents.
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
      phase_q <= '0;
      frame_q <= 16'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all
      // registers update together from the values sampled at the edge.
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      phase_q <= phase_d;
      frame_q <= frame_d;
    end
  end

endmodule

// File: tb/tb_fir_decimator.sv
// ---------------------------------------------------------------------------
// tb_fir_decimator -- scoreboard bench for fir_decimator.
// dut4 (DECIM_FACTOR=4) runs the directed decimation, back-pressure and reset
// cases; dut1 (DECIM_FACTOR=1) runs the pass-through stream and the
// frame_count wrap. Expected beats are queued by the stimulus and popped by
// per-DUT monitors whenever an output beat transfers.
// ---------------------------------------------------------------------------
module tb_fir_decimator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4, rst1;
  logic [15:0] fc4, fc1;

  fir_decimator_if #(.DATA_WIDTH(16)) s4 ();
  fir_decimator_if #(.DATA_WIDTH(16)) m4 ();
  fir_decimator_if #(.DATA_WIDTH(16)) s1 ();
  fir_decimator_if #(.DATA_WIDTH(16)) m1 ();

  fir_decimator #(.DATA_WIDTH(16), .DECIM_FACTOR(4)) dut4 (
    .clk               (clk),
    .reset             (rst4),
    .s_axis_dec_tdata  (s4.tdata),
    .s_axis_dec_tvalid (s4.tvalid),
    .s_axis_dec_tlast  (s4.tlast),
    .s_axis_dec_tready (s4.tready),
    .m_axis_dec_tdata  (m4.tdata),
    .m_axis_dec_tvalid (m4.tvalid),
    .m_axis_dec_tlast  (m4.tlast),
    .m_axis_dec_tready (m4.tready),
    .frame_count       (fc4)
  );

  fir_decimator #(.DATA_WIDTH(16), .DECIM_FACTOR(1)) dut1 (
    .clk               (clk),
    .reset             (rst1),
    .s_axis_dec_tdata  (s1.tdata),
    .s_axis_dec_tvalid (s1.tvalid),
    .s_axis_dec_tlast  (s1.tlast),
    .s_axis_dec_tready (s1.tready),
    .m_axis_dec_tdata  (m1.tdata),
    .m_axis_dec_tvalid (m1.tvalid),
    .m_axis_dec_tlast  (m1.tlast),
    .m_axis_dec_tready (m1.tready),
    .frame_count       (fc1)
  );

  int total = 0;
  int bad   = 0;

  logic [16:0] q4[$];   // {tlast, tdata}
  logic [16:0] q1[$];

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int pops1 = 0;
  int first_pop1 = 0;
  int last_pop1 = 0;
  int stalls1 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (m4.tvalid && m4.tready) begin
      if (q4.size() == 0) check("out4_extra_beat", {15'd0, m4.tlast, m4.tdata}, 32'hFFFF_FFFF);
      else                check("out4_beat", {15'd0, m4.tlast, m4.tdata}, {15'd0, q4.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (m1.tvalid && m1.tready) begin
      if (pops1 == 0) first_pop1 = cycle;
      last_pop1 = cycle;
      pops1++;
      if (q1.size() == 0) check("out1_extra_beat", {15'd0, m1.tlast, m1.tdata}, 32'hFFFF_FFFF);
      else                check("out1_beat", {15'd0, m1.tlast, m1.tdata}, {15'd0, q1.pop_front()});
    end
  end

  // ---------------- drivers (entered #1 after a rising edge) ----------------
  task automatic send4(input logic [15:0] d, input logic l);
    int n = 0;
    s4.tdata = d; s4.tlast = l; s4.tvalid = 1'b1;
    @(negedge clk);
    while (!s4.tready && n < 100) begin n++; @(negedge clk); end
    if (n >= 100) check("send4_ready_timeout", n, 0);
    @(posedge clk); #1;
    s4.tvalid = 1'b0; s4.tlast = 1'b0;
  endtask

  task automatic send1(input logic [15:0] d, input logic l);
    int n = 0;
    s1.tdata = d; s1.tlast = l; s1.tvalid = 1'b1;
    @(negedge clk);
    if (!s1.tready) stalls1++;
    while (!s1.tready && n < 100) begin n++; @(negedge clk); end
    if (n >= 100) check("send1_ready_timeout", n, 0);
    @(posedge clk); #1;
    s1.tvalid = 1'b0; s1.tlast = 1'b0;
  endtask

  task automatic drain4(input string name);
    int n = 0;
    do begin @(posedge clk); #2; n++; end while (q4.size() != 0 && n < 200);
    if (q4.size() != 0) check(name, q4.size(), 0);
  endtask

  task automatic drain1(input string name);
    int n = 0;
    do begin @(posedge clk); #2; n++; end while (q1.size() != 0 && n < 200);
    if (q1.size() != 0) check(name, q1.size(), 0);
  endtask

  // ---------------- dut4 sequence ----------------
  task automatic run_dut4();
    rst4 = 1'b1; m4.tready = 1'b0;
    s4.tvalid = 1'b0; s4.tlast = 1'b0; s4.tdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst4_m_tvalid", m4.tvalid, 0);
    check("rst4_s_tready", s4.tready, 0);
    check("rst4_m_tdata",  m4.tdata, 0);
    check("rst4_m_tlast",  m4.tlast, 0);
    check("rst4_frame_count", fc4, 0);
    @(posedge clk); #1;
    rst4 = 1'b0; m4.tready = 1'b1;
    @(posedge clk); #1;

    // 0..11, tlast on 11 -> 0,4,8,11(last)
    q4.push_back({1'b0, 16'd0});
    q4.push_back({1'b0, 16'd4});
    q4.push_back({1'b0, 16'd8});
    q4.push_back({1'b1, 16'd11});
    for (int i = 0; i < 12; i++) send4(16'(i), i == 11);
    drain4("drain_decim12");
    check("fc4_after_decim12", fc4, 1);

    // 0..5 (tlast on 5) then 100..103 -> 0,4,5(last),100
    q4.push_back({1'b0, 16'd0});
    q4.push_back({1'b0, 16'd4});
    q4.push_back({1'b1, 16'd5});
    q4.push_back({1'b0, 16'd100});
    for (int i = 0; i < 6; i++) send4(16'(i), i == 5);
    for (int i = 100; i < 104; i++) send4(16'(i), 1'b0);
    drain4("drain_short_frame");
    check("fc4_after_short_frame", fc4, 2);

    // Back-pressure: every beat carries tlast so each one is kept.
    m4.tready = 1'b0;
    q4.push_back({1'b1, 16'd200});
    q4.push_back({1'b1, 16'd201});
    q4.push_back({1'b1, 16'd202});
    send4(16'd200, 1'b1);
    send4(16'd201, 1'b1);
    @(negedge clk);
    check("bp_s_tready_low", s4.tready, 0);
    check("bp_m_tvalid",     m4.tvalid, 1);
    check("bp_head_data",    m4.tdata, 200);
    repeat (3) @(negedge clk);
    check("bp_head_stable",  {m4.tlast, m4.tdata}, {1'b1, 16'd200});
    @(posedge clk); #1;
    fork
      send4(16'd202, 1'b1);
      begin repeat (2) @(posedge clk); #1; m4.tready = 1'b1; end
    join
    drain4("drain_backpressure");
    check("fc4_after_backpressure", fc4, 5);

    // Reset mid-frame with one beat buffered: 300 kept, 301 discarded.
    m4.tready = 1'b0;
    send4(16'd300, 1'b0);
    send4(16'd301, 1'b0);
    check("pre_rst_m_tvalid", m4.tvalid, 1);
    rst4 = 1'b1;
    @(negedge clk);
    check("midrst_m_tvalid", m4.tvalid, 0);
    check("midrst_s_tready", s4.tready, 0);
    check("midrst_m_tdata",  m4.tdata, 0);
    check("midrst_m_tlast",  m4.tlast, 0);
    repeat (2) @(posedge clk); #1;
    rst4 = 1'b0;
    @(negedge clk);
    check("postrst_m_tvalid", m4.tvalid, 0);
    check("postrst_frame_count", fc4, 0);
    @(posedge clk); #1;
    m4.tready = 1'b1;
    // 400 is phase 0 again; 404 is phase 0 with tlast, kept once.
    q4.push_back({1'b0, 16'd400});
    q4.push_back({1'b1, 16'd404});
    for (int i = 400; i < 405; i++) send4(16'(i), i == 404);
    drain4("drain_after_reset");
    check("fc4_after_reset_frame", fc4, 1);
    check("q4_empty_at_end", q4.size(), 0);
  endtask

  // ---------------- dut1 sequence ----------------
  task automatic run_dut1();
    logic [15:0] d;
    rst1 = 1'b1; m1.tready = 1'b1;
    s1.tvalid = 1'b0; s1.tlast = 1'b0; s1.tdata = '0;
    repeat (2) @(posedge clk); #1;
    rst1 = 1'b0;
    @(posedge clk); #1;

    // 2048-beat pass-through stream at full rate.
    pops1 = 0; stalls1 = 0;
    for (int i = 0; i < 2048; i++) begin
      d = 16'(i * 97 + 16'h8000);
      q1.push_back({i == 2047, d});
      send1(d, i == 2047);
    end
    drain1("drain_stream");
    check("stream_pop_count", pops1, 2048);
    check("stream_input_stalls", stalls1, 0);
    check("stream_output_span", last_pop1 - first_pop1, 2047);
    check("fc1_after_stream", fc1, 1);

    rst1 = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst1 = 1'b0;
    @(negedge clk);
    check("fc1_after_reset", fc1, 0);
    @(posedge clk); #1;

    // Single-beat frames: count up to 0xFFFF, then one more wraps to 0.
    for (int i = 0; i < 65535; i++) begin
      q1.push_back({1'b1, 16'(i)});
      send1(16'(i), 1'b1);
    end
    drain1("drain_wrap_a");
    check("fc1_at_ffff", fc1, 32'h0000_FFFF);
    q1.push_back({1'b1, 16'hABCD});
    send1(16'hABCD, 1'b1);
    drain1("drain_wrap_b");
    check("fc1_wrapped", fc1, 0);
    check("q1_empty_at_end", q1.size(), 0);
  endtask

  initial begin
    fork
      run_dut4();
      run_dut1();
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fir_decimator.md
FIR_DECIMATOR -- requirements
Module: fir_decimator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, sample width in bits (two's complement).
REQ-002 SHALL have parameter DECIM_FACTOR, default 4, keep-one-in-N ratio; legal range 1..256.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port s_axis_dec_tdata  input  DATA_WIDTH  filtered sample from the FIR stage.
REQ-006 SHALL have port s_axis_dec_tvalid  input  1  upstream data valid.
REQ-007 SHALL have port s_axis_dec_tlast  input  1  last sample of the frame.
REQ-008 SHALL have port s_axis_dec_tready  output  1  block can accept a beat.
REQ-009 SHALL have port m_axis_dec_tdata  output  DATA_WIDTH  decimated sample.
REQ-010 SHALL have port m_axis_dec_tvalid  output  1  output data valid.
REQ-011 SHALL have port m_axis_dec_tlast  output  1  last decimated sample of the frame.
REQ-012 SHALL have port m_axis_dec_tready  input  1  downstream can accept a beat.
REQ-013 SHALL have port frame_count  output  16  number of frames completed at the output, wrapping.

Function
REQ-014 SHALL transfer a beat only when tvalid and tready are both high at a rising edge, on either interface.
REQ-015 SHALL hold a phase counter in 0..DECIM_FACTOR-1, advanced by 1 on each accepted input beat, wrapping from DECIM_FACTOR-1 to 0.
REQ-016 SHALL keep an accepted input beat when phase == 0 or s_axis_dec_tlast == 1. All other accepted beats are discarded.
REQ-017 SHALL force phase to 0 after accepting a tlast beat, so every frame starts with a kept sample.
REQ-018 SHALL store kept beats (data, tlast) in a 2-entry FIFO. The output presents the FIFO head.
REQ-019 SHALL drive s_axis_dec_tready = (FIFO occupancy < 2) and not reset. It is registered or derived from registered state only, with no combinational path from m_axis_dec_tready.
REQ-020 SHALL drive m_axis_dec_tvalid = (occupancy != 0). tdata and tlast SHALL stay stable while tvalid=1 and tready=0.
REQ-021 SHALL have a latency of one cycle: a kept beat accepted at edge k into an empty FIFO appears with m_axis_dec_tvalid=1 immediately after edge k.
REQ-022 SHALL handle a push and a pop in the same cycle with occupancy 1 by keeping occupancy at 1 and moving the new beat to the head.
REQ-023 SHALL, on a discarded beat, leave the FIFO untouched; a simultaneous pop still occurs.
REQ-024 SHALL pass every beat unchanged when DECIM_FACTOR = 1.
REQ-025 SHALL increment frame_count on each accepted output beat with m_axis_dec_tlast=1, wrapping 0xFFFF to 0.
REQ-026 SHALL pass data unmodified: no rounding, scaling or sign change.
REQ-027 SHALL treat a tlast beat arriving at phase 0 as a single kept beat; it is not duplicated.

Reset
REQ-028 SHALL, while reset is high at an edge, set occupancy=0, phase=0 and frame_count=0.
REQ-029 SHALL hold the following output values during reset: m_axis_dec_tvalid=0, m_axis_dec_tlast=0, m_axis_dec_tdata=0, s_axis_dec_tready=0.
REQ-030 SHALL abandon any in-flight frame on reset mid-operation, discarding FIFO contents. The first beat accepted after reset is treated as phase 0.

Verification
REQ-031 SHALL cover this scenario: DECIM_FACTOR=4, tready=1, inputs 0..11 with tlast on 11 -> output 0,4,8,11; tlast only on 11; frame_count=1.
REQ-032 SHALL cover this scenario: DECIM_FACTOR=4, frame of 6 beats (tlast on 5) then a new frame 100..103 -> output 0,4,5(tlast),100.
REQ-033 SHALL cover this scenario: m_axis_dec_tready=0 with continuous valid input -> FIFO fills to 2, s_axis_dec_tready drops, and no data is lost or reordered after release.
REQ-034 SHALL cover this scenario: DECIM_FACTOR=1, 2048-sample stream with tlast on the last beat -> 2048 identical outputs in order, one per cycle at full throughput, and frame_count=1.
REQ-035 SHALL cover this scenario: reset asserted for 2 cycles mid-frame with 1 beat buffered -> tvalid=0 next cycle, buffered beat lost; next accepted input is kept (phase 0).
REQ-036 SHALL cover this scenario: 65536 single-beat frames -> frame_count wraps to 0.
